// File: rtl/nexys_starship_pkg.sv
// Shared types and defaults for the starship bottom-monster defender slice.
// One-hot state encodings plus the saturating score helper.
package nexys_starship_pkg;

   localparam int unsigned DEF_TIMEOUT        = 500000000;
   localparam int unsigned DEF_REPAIR_PRESSES = 4;

   typedef enum logic [3:0] {
      S_IDLE   = 4'b0001,
      S_ARMED  = 4'b0010,
      S_BROKEN = 4'b0100,
      S_OVER   = 4'b1000
   } state_t;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/nexys_starship_timer.sv
// Deadline counter: counts while enabled, returns to zero otherwise.
// Expire flags the enabled cycle holding TIMEOUT-1.
module nexys_starship_timer
   import nexys_starship_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
)(
   input  logic Clk,
   input  logic Reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam logic [31:0] LAST = 32'(TIMEOUT - 1);

   logic [31:0] r_cnt;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         r_cnt <= '0;
      else if (i_clear)
         r_cnt <= '0;
      else if (i_enable)
         r_cnt <= r_cnt + 32'd1;
   end

   assign o_expire = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/nexys_starship_bm_defender.sv
// Bottom-monster gun: kill, break/repair and timeout game-over control.
// Single registered FSM; all outputs come straight from flops.
module nexys_starship_bm_defender
   import nexys_starship_pkg::*;
#(
   parameter int unsigned TIMEOUT        = DEF_TIMEOUT,
   parameter int unsigned REPAIR_PRESSES = DEF_REPAIR_PRESSES
)(
   input  logic       Clk,
   input  logic       Reset,
   input  logic       play_flag,
   input  logic       btm_monster,
   input  logic       btn_fire,
   input  logic       btn_repair,
   output logic       btm_kill,
   output logic       btm_broken,
   output logic       game_over,
   output logic [7:0] score,
   output logic       q_Idle,
   output logic       q_Armed,
   output logic       q_Broken,
   output logic       q_Over
);

   localparam logic [7:0] REP_LAST = 8'(REPAIR_PRESSES - 1);

   state_t     r_state;
   logic       r_kill;
   logic       r_broken;
   logic       r_over;
   logic       r_kill_wait;
   logic [7:0] r_score;
   logic [7:0] r_rep_cnt;

   logic w_active;
   logic w_tmr_en;
   logic w_tmr_clr;
   logic w_expire;
   logic w_kill_fire;

   assign w_active    = (r_state == S_ARMED) || (r_state == S_BROKEN);
   assign w_tmr_en    = w_active && btm_monster && !r_kill_wait;
   assign w_kill_fire = (r_state == S_ARMED) && play_flag && btn_fire &&
                        btm_monster && !r_kill_wait;
   // A kill restarts the deadline even on the expiring cycle
   assign w_tmr_clr   = !w_tmr_en || w_kill_fire || !play_flag;

   nexys_starship_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .Clk      (Clk),
      .Reset    (Reset),
      .i_clear  (w_tmr_clr),
      .i_enable (w_tmr_en),
      .o_expire (w_expire)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state     <= S_IDLE;
         r_kill      <= 1'b0;
         r_broken    <= 1'b0;
         r_over      <= 1'b0;
         r_kill_wait <= 1'b0;
         r_score     <= '0;
         r_rep_cnt   <= '0;
      end else begin
         r_kill <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               r_broken <= 1'b0;
               if (play_flag) begin
                  r_state     <= S_ARMED;
                  r_score     <= '0;
                  r_rep_cnt   <= '0;
                  r_kill_wait <= 1'b0;
               end
            end
            S_ARMED: begin
               if (!play_flag) begin
                  r_state  <= S_IDLE;
                  r_broken <= 1'b0;
               end else if (w_kill_fire) begin
                  r_kill      <= 1'b1;
                  r_score     <= sat_inc(r_score);
                  r_kill_wait <= 1'b1;
               end else if (w_expire) begin
                  r_state <= S_OVER;
                  r_over  <= 1'b1;
               end else begin
                  if (!btm_monster)
                     r_kill_wait <= 1'b0;
                  if (btn_fire && !r_kill_wait) begin
                     r_state   <= S_BROKEN;
                     r_broken  <= 1'b1;
                     r_rep_cnt <= '0;
                  end
               end
            end
            S_BROKEN: begin
               if (!play_flag) begin
                  r_state  <= S_IDLE;
                  r_broken <= 1'b0;
               end else if (w_expire) begin
                  r_state <= S_OVER;
                  r_over  <= 1'b1;
               end else begin
                  if (!btm_monster)
                     r_kill_wait <= 1'b0;
                  if (btn_repair) begin
                     r_rep_cnt <= r_rep_cnt + 8'd1;
                     if (r_rep_cnt == REP_LAST) begin
                        r_state  <= S_ARMED;
                        r_broken <= 1'b0;
                     end
                  end
               end
            end
            S_OVER: begin
               r_over <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign btm_kill   = r_kill;
   assign btm_broken = r_broken;
   assign game_over  = r_over;
   assign score      = r_score;
   assign q_Idle     = (r_state == S_IDLE);
   assign q_Armed    = (r_state == S_ARMED);
   assign q_Broken   = (r_state == S_BROKEN);
   assign q_Over     = (r_state == S_OVER);

endmodule

// File: tb/tb_nexys_starship_bm_defender.sv
// Scoreboard bench for the bottom-monster defender (TIMEOUT=8, 3 repairs).
// Driver queues per-cycle expectations; a negedge monitor pops and compares.
module tb_nexys_starship_bm_defender;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       play_flag;
   logic       btm_monster;
   logic       btn_fire;
   logic       btn_repair;
   logic       btm_kill;
   logic       btm_broken;
   logic       game_over;
   logic [7:0] score;
   logic       q_Idle;
   logic       q_Armed;
   logic       q_Broken;
   logic       q_Over;

   localparam logic [3:0] SI = 4'b0001;
   localparam logic [3:0] SA = 4'b0010;
   localparam logic [3:0] SB = 4'b0100;
   localparam logic [3:0] SO = 4'b1000;

   typedef struct packed {
      logic [3:0] st;
      logic       k;
      logic       b;
      logic       o;
      logic [7:0] sc;
   } obs_t;

   typedef struct {
      int    tag;
      obs_t  v;
      string nm;
   } ent_t;

   ent_t sbq[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   obs_t act;

   nexys_starship_bm_defender #(
      .TIMEOUT        (8),
      .REPAIR_PRESSES (3)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .play_flag   (play_flag),
      .btm_monster (btm_monster),
      .btn_fire    (btn_fire),
      .btn_repair  (btn_repair),
      .btm_kill    (btm_kill),
      .btm_broken  (btm_broken),
      .game_over   (game_over),
      .score       (score),
      .q_Idle      (q_Idle),
      .q_Armed     (q_Armed),
      .q_Broken    (q_Broken),
      .q_Over      (q_Over)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   assign act = {q_Over, q_Broken, q_Armed, q_Idle,
                 btm_kill, btm_broken, game_over, score};

   function automatic obs_t ex(input logic [3:0] st, input logic k,
                               input logic b, input logic o,
                               input logic [7:0] sc);
      return {st, k, b, o, sc};
   endfunction

   always @(negedge Clk) begin
      ent_t e;
      checks++;
      if (!$onehot({q_Over, q_Broken, q_Armed, q_Idle})) begin
         errors++;
         $display("FAIL onehot cyc=%0d: got=%b want one bit",
                  cyc, {q_Over, q_Broken, q_Armed, q_Idle});
      end
      while (sbq.size() > 0 && sbq[0].tag <= cyc) begin
         e = sbq.pop_front();
         checks++;
         if (e.tag != cyc || act !== e.v) begin
            errors++;
            $display("FAIL %s cyc=%0d tag=%0d: got=%h want=%h",
                     e.nm, cyc, e.tag, act, e.v);
         end
      end
   end

   task automatic push(input int tag, input obs_t v, input string nm);
      ent_t e;
      e.tag = tag;
      e.v   = v;
      e.nm  = nm;
      sbq.push_back(e);
   endtask

   task automatic step(input logic pf, input logic mon, input logic fr,
                       input logic rp, input obs_t e, input string nm);
      play_flag   = pf;
      btm_monster = mon;
      btn_fire    = fr;
      btn_repair  = rp;
      push(cyc + 1, e, nm);
      @(posedge Clk);
      #1;
      btn_fire   = 1'b0;
      btn_repair = 1'b0;
   endtask

   task automatic do_reset(input string nm);
      @(negedge Clk);
      #1;
      @(posedge Clk);
      #1;
      Reset       = 1'b1;
      play_flag   = 1'b0;
      btm_monster = 1'b0;
      push(cyc, ex(SI, 0, 0, 0, 8'd0), nm);
      @(posedge Clk);
      #1;
      Reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] sat;
      Reset       = 1'b0;
      play_flag   = 1'b0;
      btm_monster = 1'b0;
      btn_fire    = 1'b0;
      btn_repair  = 1'b0;
      #1 Reset = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      push(cyc, ex(SI, 0, 0, 0, 8'd0), "reset");
      @(posedge Clk);
      #1;
      Reset = 1'b0;

      step(1, 0, 0, 0, ex(SA, 0, 0, 0, 8'd0), "arm");
      repeat (3) step(1, 1, 0, 0, ex(SA, 0, 0, 0, 8'd0), "mon_t");
      step(1, 1, 1, 0, ex(SA, 1, 0, 0, 8'd1), "kill_t3");
      repeat (3) step(1, 1, 1, 0, ex(SA, 0, 0, 0, 8'd1), "kw_ign");
      step(1, 0, 0, 0, ex(SA, 0, 0, 0, 8'd1), "kw_clr");

      step(1, 0, 1, 0, ex(SB, 0, 1, 0, 8'd1), "break");
      step(1, 0, 1, 0, ex(SB, 0, 1, 0, 8'd1), "brk_fire");
      step(1, 0, 0, 1, ex(SB, 0, 1, 0, 8'd1), "rep1");
      step(1, 0, 0, 0, ex(SB, 0, 1, 0, 8'd1), "rep_gap");
      step(1, 0, 0, 1, ex(SB, 0, 1, 0, 8'd1), "rep2");
      step(1, 0, 0, 1, ex(SA, 0, 0, 0, 8'd1), "rep3");
      step(1, 0, 0, 1, ex(SA, 0, 0, 0, 8'd1), "rep_armed");

      repeat (7) step(1, 1, 0, 0, ex(SA, 0, 0, 0, 8'd1), "mon7");
      step(1, 1, 1, 0, ex(SA, 1, 0, 0, 8'd2), "kill_t7");
      step(1, 0, 0, 0, ex(SA, 0, 0, 0, 8'd2), "post_t7");
      step(0, 0, 0, 0, ex(SI, 0, 0, 0, 8'd2), "idle");

      step(1, 1, 0, 0, ex(SA, 0, 0, 0, 8'd0), "rearm");
      repeat (7) step(1, 1, 0, 0, ex(SA, 0, 0, 0, 8'd0), "tmo_run");
      step(1, 1, 0, 0, ex(SO, 0, 0, 1, 8'd0), "timeout");
      step(1, 1, 1, 1, ex(SO, 0, 0, 1, 8'd0), "over_hold");
      step(0, 0, 1, 0, ex(SO, 0, 0, 1, 8'd0), "over_hold2");
      do_reset("rst_over");

      step(1, 0, 0, 0, ex(SA, 0, 0, 0, 8'd0), "arm2");
      for (int i = 0; i < 256; i++) begin
         sat = (i >= 254) ? 8'd255 : 8'(i + 1);
         step(1, 1, 1, 0, ex(SA, 1, 0, 0, sat), "kill_n");
         step(1, 0, 0, 0, ex(SA, 0, 0, 0, sat), "kill_rel");
      end

      step(1, 0, 1, 0, ex(SB, 0, 1, 0, 8'd255), "break2");
      step(1, 0, 0, 1, ex(SB, 0, 1, 0, 8'd255), "rep_a");
      step(1, 0, 0, 1, ex(SB, 0, 1, 0, 8'd255), "rep_b");
      do_reset("rst_rep");
      step(1, 0, 0, 0, ex(SA, 0, 0, 0, 8'd0), "arm3");

      @(negedge Clk);
      #1;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain: got=%0d pending want=0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nexys_starship_bm_defender.md
NEXYS_STARSHIP_BM_DEFENDER -- requirements
Module: nexys_starship_bm_defender

Interface
REQ-001 SHALL have parameter TIMEOUT, default 500000000, cycles a bottom monster may persist before game over (5 s at 100 MHz).
REQ-002 SHALL have parameter REPAIR_PRESSES, default 4, repair pulses needed to clear a broken gun.
REQ-003 SHALL have port Clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  reset; Reset, asynchronous, active-high; clock Clk.
REQ-005 SHALL have port play_flag  input  1  game running; low returns the block to IDLE.
REQ-006 SHALL have port btm_monster  input  1  level from the bottom-monster FSM; high = monster present.
REQ-007 SHALL have port btn_fire  input  1  debounced single-cycle fire pulse.
REQ-008 SHALL have port btn_repair  input  1  debounced single-cycle repair pulse.
REQ-009 SHALL have port btm_kill  output  1  single-cycle kill acknowledge to the bottom-monster FSM.
REQ-010 SHALL have port btm_broken  output  1  gun broken.
REQ-011 SHALL have port game_over  output  1  monster timed out; sticky.
REQ-012 SHALL have port score  output  8  kills this game, saturating.
REQ-013 SHALL have ports q_Idle, q_Armed, q_Broken, q_Over  output  1 each  one-hot state bits.

Function
REQ-014 SHALL implement the one-hot FSM IDLE, ARMED, BROKEN, OVER; exactly one q_* bit high at all times.
REQ-015 IDLE: outputs low, score held; play_flag=1 -> ARMED next cycle, with score, timer, repair count and kill_wait cleared.
REQ-016 ARMED/BROKEN with play_flag=0 -> IDLE next cycle; score held; btm_broken cleared.
REQ-017 Timer SHALL increment each cycle in ARMED or BROKEN while btm_monster=1 and kill_wait=0; otherwise it SHALL hold at 0.
REQ-018 ARMED, btn_fire=1, btm_monster=1, kill_wait=0: btm_kill=1 on the next cycle for exactly one cycle; score+1 (saturate at 255); timer cleared; kill_wait set.
REQ-019 kill_wait SHALL clear on the first cycle btm_monster=0; while kill_wait=1, btn_fire SHALL be ignored (no kill, no break).
REQ-020 ARMED, btn_fire=1, btm_monster=0, kill_wait=0: -> BROKEN next cycle; btm_broken=1; repair count cleared.
REQ-021 BROKEN: btn_fire ignored; each btn_repair pulse increments repair count; the pulse making it REPAIR_PRESSES -> ARMED next cycle, btm_broken=0.
REQ-022 Timer value TIMEOUT-1 while btm_monster=1 in ARMED or BROKEN -> OVER next cycle; game_over=1.
REQ-023 A valid kill fire (REQ-018) in the same cycle as timeout SHALL win: kill issued, no OVER.
REQ-024 OVER: game_over=1, btm_kill=0, btm_broken and score held; inputs ignored; left only by Reset.
REQ-025 btn_repair outside BROKEN SHALL be ignored.
REQ-026 Timer SHALL be 32 bits wide; TIMEOUT SHALL be at least 2.

Reset
REQ-027 Reset=1 SHALL immediately force IDLE, btm_kill=0, btm_broken=0, game_over=0, score=0, timer=0, repair count=0, kill_wait=0, including mid-kill or mid-repair.
REQ-028 The first edge after Reset deasserts SHALL evaluate IDLE transitions normally.

Structure
REQ-029 State encodings and TIMEOUT/REPAIR_PRESSES defaults SHALL live in shared package nexys_starship_pkg.
REQ-030 The deadline counter SHALL be sub-module nexys_starship_timer (clear, enable, expire at TIMEOUT-1).

Verification (TIMEOUT=8, REPAIR_PRESSES=3)
REQ-031 play_flag=1, btm_monster=1, fire at timer=3 -> btm_kill one cycle later for one cycle; score=1; no OVER.
REQ-032 play_flag=1, btm_monster=1 for 8 cycles, no fire -> q_Over=1, game_over=1 on cycle 8; later fire/Reset-free cycles keep it.
REQ-033 fire with btm_monster=0 -> btm_broken=1; fire ignored; 3 repair pulses -> q_Armed, btm_broken=0.
REQ-034 After kill, btm_monster held high 3 cycles with fire every cycle -> exactly one btm_kill, score=1, no BROKEN.
REQ-035 fire coincident with timer=7 -> btm_kill, no game_over; 256 kills -> score=255.
REQ-036 Reset asserted mid-repair (count=2) -> all outputs 0, q_Idle=1 within the same cycle.
